// File: rtl/fifo_rr_drain_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: combinational round-robin picker.
//
// The search starts at bit `ptr` of `req` and wraps modulo N. It works on a
// double-width vector {req, req & mask}. The mask clears bits below ptr, so a
// lowest-set-bit search finds the first request at or above the pointer. If
// there is none, the search falls through to the unmasked upper copy, which
// gives the wrap-around.
//
// Ports
//   req   in  N : request vector, bit i = source i wants service
//   ptr   in  W : priority pointer, 0..N-1
//   grant out N : one-hot grant, zero when no request
//   idx   out W : encoded index of the granted source (0 when none)
//   any   out 1 : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    int             hit;

    // Keep only requests at positions >= ptr in the low half.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign dbl = {req, req & mask};

    // Lowest set bit of the double-width vector. Scanning downward lets the
    // last assignment win, which leaves the lowest position in `hit`.
    always_comb begin
        hit = 0;
        any = 1'b0;
        for (int k = 2 * N - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                hit = k;
                any = 1'b1;
            end
        end
    end

    // A hit in the upper copy maps back onto the same source index.
    always_comb begin
        idx = '0;
        if (hit >= N) begin
            idx = W'(hit - N);
        end else begin
            idx = W'(hit);
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = any && (idx == W'(i));
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// -----------------------------------------------------------------------------
// fifo_rr_drain: round-robin drain stage for up to NUM_SRC synchronous FIFOs.
//
// This block reads the FIFOs through their native read interface and presents
// one registered valid/ready stream. Each beat is tagged with the index of the
// source FIFO it came from.
//
// Handshake: a beat is held in the output register while out_valid_o is 1. It
// transfers on every rising edge where out_valid_o && out_ready_i. While
// out_valid_o is 1 and out_ready_i is 0, the payload and tag stay stable.
//
// Ports
//   clk          in  1                  : clock
//   rst_n        in  1                  : asynchronous active-low reset
//   src_empty_i  in  NUM_SRC            : FIFO i empty flag
//   src_data_i   in  NUM_SRC*DATA_WIDTH : FIFO i read data at [DW*(i+1)-1 -: DW]
//   src_r_en_o   out NUM_SRC            : one-hot-or-zero pop strobe to FIFO i
//   out_valid_o  out 1                  : output register holds a beat
//   out_ready_i  in  1                  : downstream accepts the beat
//   out_data_o   out DATA_WIDTH         : registered payload
//   out_src_o    out SRC_ID_WIDTH       : source index of the payload
// -----------------------------------------------------------------------------
module fifo_rr_drain #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int NUM_SRC      = 4,
    localparam int SRC_ID_WIDTH = (NUM_SRC == 1) ? 1 : $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_empty_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    output logic [NUM_SRC-1:0]            src_r_en_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [SRC_ID_WIDTH-1:0]       out_src_o
);

    logic [SRC_ID_WIDTH-1:0] rr_ptr;
    logic [SRC_ID_WIDTH-1:0] next_ptr;
    logic [NUM_SRC-1:0]      grant;
    logic [SRC_ID_WIDTH-1:0] win_idx;
    logic                    win_any;
    logic                    load_ok;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   win_data;

    rr_pick #(
        .N (NUM_SRC),
        .W (SRC_ID_WIDTH)
    ) u_pick (
        .req   (~src_empty_i),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // The output register can take a new beat when it is empty, or when its
    // current beat leaves this cycle. In the second case the two overlap with
    // no bubble.
    assign load_ok = !out_valid_o || out_ready_i;

    // The FIFOs do not guard reads on empty, so the strobe is qualified by
    // win_any, which comes only from non-empty sources. It is also gated by
    // rst_n so no FIFO is popped while reset is asserted.
    assign pop        = rst_n && load_ok && win_any;
    assign src_r_en_o = pop ? grant : '0;

    // The FIFO shows its head entry combinationally, so the winner's current
    // data is the entry being popped.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == SRC_ID_WIDTH'(i)) begin
                win_data = src_data_i[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Priority moves to the source after the winner. For NUM_SRC==1 this
    // always gives 0.
    assign next_ptr = (win_idx == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_src_o   <= '0;
            rr_ptr      <= '0;
        end else if (pop) begin
            out_valid_o <= 1'b1;
            out_data_o  <= win_data;
            out_src_o   <= win_idx;
            rr_ptr      <= next_ptr;
        end else if (out_ready_i) begin
            // The beat was consumed, or the register was already empty.
            // Data and tag keep their last values.
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
module tb_fifo_rr_drain;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = 2;

  // ---------------- clock / reset ----------------
  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [NS-1:0]   src_empty_i = '1;
  logic [NS*DW-1:0] src_data_i = '0;
  logic [NS-1:0]   src_r_en_o;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [DW-1:0]   out_data_o;
  logic [SW-1:0]   out_src_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_rr_drain #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_empty_i (src_empty_i),
    .src_data_i  (src_data_i),
    .src_r_en_o  (src_r_en_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o)
  );

  // ---------------- upstream FIFO models and logs ----------------
  logic [DW-1:0] fq [NS][$];
  logic [NS-1:0] en_s = '0;

  logic [DW-1:0] acc_data[$];
  logic [SW-1:0] acc_src[$];
  int            acc_cyc[$];
  logic [DW-1:0] exp_q[$];
  logic [SW-1:0] exp_src[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NS; i++) begin
      src_empty_i[i] = (fq[i].size() == 0);
      src_data_i[DW*i +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock. Apply the pops that were sampled before the edge.
  // The task returns just after the edge, which is where stimulus changes.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NS; i++) begin
      if (en_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    #1;
    refresh();
  endtask

  task automatic clear_logs();
    acc_data.delete();
    acc_src.delete();
    acc_cyc.delete();
    exp_q.delete();
    exp_src.delete();
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_q.push_back(d);
    exp_src.push_back(s);
  endtask

  task automatic wait_beats(input int n, input string name);
    int budget;
    budget = 40;
    while (acc_data.size() < n && budget > 0) begin
      step();
      budget--;
    end
    check({name, "_arrived"}, 64'(acc_data.size() >= n), 64'd1);
  endtask

  task automatic check_log(input string name, input bit consec);
    check({name, "_count"}, 64'(acc_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_data.size(); i++) begin
      check({name, "_data"}, 64'(acc_data[i]), 64'(exp_q[i]));
      check({name, "_src"}, 64'(acc_src[i]), 64'(exp_src[i]));
      if (consec && i > 0) check({name, "_gap"}, 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd1);
    end
    clear_logs();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) fq[i].delete();
    refresh();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard / model ----------------
  // This is a transaction-level view of the stage. At each sample point it
  // holds the beat the output register must contain and the rotating
  // priority start. From the FIFO contents it works out which source must be
  // popped.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic [SW-1:0] m_src   = '0;
  int            m_ptr   = 0;

  always @(negedge clk) begin
    logic          found;
    int            win;
    int            s;
    logic [NS-1:0] exp_en;
    if (!rst_n) begin
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_r_en", 64'(src_r_en_o), 64'd0);
      check("rst_data", 64'(out_data_o), 64'd0);
      check("rst_src", 64'(out_src_o), 64'd0);
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
      m_ptr   = 0;
      en_s    = '0;
    end else begin
      check("valid", 64'(out_valid_o), 64'(m_valid));
      if (m_valid) begin
        check("data", 64'(out_data_o), 64'(m_data));
        check("src", 64'(out_src_o), 64'(m_src));
      end
      if (out_valid_o && out_ready_i) begin
        acc_data.push_back(out_data_o);
        acc_src.push_back(out_src_o);
        acc_cyc.push_back(cyc);
      end
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < NS; k++) begin
        s = (m_ptr + k) % NS;
        if (!found && fq[s].size() > 0) begin
          found = 1'b1;
          win   = s;
        end
      end
      exp_en = '0;
      if ((!m_valid || out_ready_i) && found) exp_en[win] = 1'b1;
      check("r_en", 64'(src_r_en_o), 64'(exp_en));
      en_s = src_r_en_o;
      if (exp_en != '0) begin
        m_valid = 1'b1;
        m_data  = fq[win][0];
        m_src   = SW'(win);
        m_ptr   = (win + 1) % NS;
      end else if (out_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #2;
    rst_n = 1'b0;
    out_ready_i = 1'b0;
    refresh();
    step();
    step();
    rst_n = 1'b1;

    // Idle after reset: nothing is popped and the outputs stay zero.
    out_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_valid", 64'(out_valid_o), 64'd0);
      check("idle_r_en", 64'(src_r_en_o), 64'd0);
      check("idle_data", 64'(out_data_o), 64'd0);
      check("idle_src", 64'(out_src_o), 64'd0);
    end

    // Single source.
    clear_logs();
    fq[2].push_back(32'hA0);
    fq[2].push_back(32'hA1);
    fq[2].push_back(32'hA2);
    refresh();
    expect_beat(32'hA0, 2'd2);
    expect_beat(32'hA1, 2'd2);
    expect_beat(32'hA2, 2'd2);
    wait_beats(3, "single");
    check("single_drained_valid", 64'(out_valid_o), 64'd0);
    check("single_fifo_empty", 64'(fq[2].size()), 64'd0);
    check_log("single", 1'b1);

    // Fairness from a fresh pointer.
    reset_dut();
    clear_logs();
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < 3; r++) fq[s].push_back(DW'(32'h100 * s + r));
    refresh();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NS; s++) expect_beat(DW'(32'h100 * s + r), SW'(s));
    wait_beats(12, "fair");
    check_log("fair", 1'b1);

    // Backpressure. The pointer is back at 0 and only FIFO 1 has data.
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) fq[1].push_back(DW'(32'hB0 + i));
    refresh();
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 64'(out_valid_o), 64'd1);
      check("bp_data", 64'(out_data_o), 64'hB0);
      check("bp_src", 64'(out_src_o), 64'd1);
      check("bp_r_en", 64'(src_r_en_o), 64'd0);
      step();
    end
    clear_logs();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) expect_beat(DW'(32'hB0 + i), 2'd1);
    wait_beats(4, "bp");
    check_log("bp", 1'b1);

    // Pointer skip. Granting source 0 moves the pointer to 1. Then only
    // sources 0 and 3 are non-empty.
    fq[0].push_back(32'hC0);
    refresh();
    expect_beat(32'hC0, 2'd0);
    wait_beats(1, "ptr_setup");
    check_log("ptr_setup", 1'b0);
    step();
    fq[0].push_back(32'hD0);
    fq[3].push_back(32'hD3);
    refresh();
    expect_beat(32'hD3, 2'd3);
    expect_beat(32'hD0, 2'd0);
    wait_beats(2, "skip");
    check_log("skip", 1'b1);
    step();
    check("skip_model_ptr", 64'(m_ptr), 64'd1);
    fq[0].push_back(32'hE0);
    fq[1].push_back(32'hE1);
    refresh();
    expect_beat(32'hE1, 2'd1);
    expect_beat(32'hE0, 2'd0);
    wait_beats(2, "after_skip");
    check_log("after_skip", 1'b1);

    // Reset in the middle of a stream.
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < 5; r++) fq[s].push_back(DW'(32'h200 + 32'h10 * s + r));
    refresh();
    step();
    step();
    step();
    check("mid_valid_before", 64'(out_valid_o), 64'd1);
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) fq[i].delete();
    refresh();
    #1;
    check("mid_valid_drop", 64'(out_valid_o), 64'd0);
    check("mid_r_en", 64'(src_r_en_o), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
    for (int s = 0; s < NS; s++) fq[s].push_back(DW'(32'h300 + s));
    refresh();
    for (int s = 0; s < NS; s++) expect_beat(DW'(32'h300 + s), SW'(s));
    wait_beats(4, "post_rst");
    check_log("post_rst", 1'b1);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin drain stage that sits directly downstream of up to `NUM_SRC` synchronous `fifo` instances. It reads them through their native `r_en_i`/`empty_o`/`r_data_o` interface and presents one registered valid/ready stream tagged with the source index. It never pops an empty FIFO, because the FIFO itself does not guard reads on empty. It sustains one transfer per cycle under continuous downstream ready.

## Interface
- `DATA_WIDTH`, 32: payload width; must equal the upstream FIFOs' `DATA_WIDTH`.
- `NUM_SRC`, 4: number of upstream FIFOs, ≥1.
- `SRC_ID_WIDTH` (localparam): `NUM_SRC==1 ? 1 : $clog2(NUM_SRC)`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `src_empty_i`  in  NUM_SRC: bit i is FIFO i `empty_o`.
- `src_data_i`  in  NUM_SRC*DATA_WIDTH: flattened FIFO read data; source i occupies `[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]`.
- `src_r_en_o`  out  NUM_SRC: one-hot-or-zero pop strobe, bit i drives FIFO i `r_en_i`.
- `out_valid_o`  out  1: output register holds a beat.
- `out_ready_i`  in  1: downstream accepts the beat this cycle.
- `out_data_o`  out  DATA_WIDTH: registered payload.
- `out_src_o`  out  SRC_ID_WIDTH: index of the FIFO that supplied the payload.

## Operation
- State:
  - output register (`out_valid_o`, `out_data_o`, `out_src_o`);
  - round-robin pointer `rr_ptr` (SRC_ID_WIDTH bits, range 0..NUM_SRC-1).
- `load_ok = !out_valid_o || out_ready_i`.
- Grant:
  - Candidate set is `~src_empty_i`.
  - Winner is the first set bit scanning `rr_ptr, rr_ptr+1, …`, wrapping modulo NUM_SRC.
- Pop:
  - If `load_ok` and a winner w exists, `src_r_en_o = 1<<w`; otherwise `src_r_en_o = 0`.
  - `src_r_en_o` is never asserted for a source whose `src_empty_i` bit is 1.
  - `src_r_en_o` is never asserted while `rst_n` is low.
- On a pop edge:
  - `out_data_o <= src_data_i[w]`, `out_src_o <= w`, `out_valid_o <= 1`;
  - `rr_ptr <= (w==NUM_SRC-1) ? 0 : w+1`.
- No pop and `out_valid_o && out_ready_i`: `out_valid_o <= 0`; data and src hold their last values.
- No pop and not consumed: all state holds. Once `out_valid_o` is set, data and src are stable until the handshake completes.
- Simultaneous consume and pop in the same cycle: the new beat replaces the old one with no bubble.
- `rr_ptr` advances only on a grant; idle cycles do not move it.
- NUM_SRC==1: the winner is always 0 and `rr_ptr` stays 0.
- Reset, including mid-transfer:
  - `out_valid_o=0`, `out_data_o=0`, `out_src_o=0`, `rr_ptr=0`.
  - A beat held in the output register is discarded.
  - The upstream FIFOs share `rst_n` and are cleared too.

## Timing
- Pop strobe is combinational from `src_empty_i`, `out_valid_o`, `out_ready_i` and `rr_ptr`. It is meant for the FIFO's registered `r_ptr`, so the FIFO presents its next entry one cycle later.
- Latency: a FIFO non-empty in cycle t with `load_ok` produces `out_valid_o=1` in cycle t+1.
- Throughput: one beat per cycle while `out_ready_i` is held high and any source is non-empty.
- Backpressure: while `out_valid_o && !out_ready_i`, no FIFO is popped.
- `out_ready_i` has a combinational path to `src_r_en_o`. This is permitted; the output register breaks the data path.

## Structure
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Implemented as a double-width masked priority search.
- Top level holds the output register, `rr_ptr` and the data mux.
- No shared package. `SRC_ID_WIDTH` is a local derived parameter, and the module must elaborate standalone next to `fifo`.

## Test plan
- Reset then idle: all `src_empty_i=1` for 10 cycles -> `src_r_en_o=0`, `out_valid_o=0`, outputs 0.
- Single source: FIFO 2 preloaded with 0xA0, 0xA1, 0xA2, `out_ready_i=1` -> those three values on consecutive cycles with `out_src_o=2`, then `out_valid_o=0`; FIFO 2 ends empty and never underflows.
- Fairness: all 4 FIFOs hold 3 entries each, ready=1 -> `out_src_o` sequence 0,1,2,3,0,1,2,3,0,1,2,3, with 12 beats in 12 consecutive cycles.
- Backpressure: `out_ready_i=0` for 5 cycles with data pending -> `out_data_o`/`out_src_o` stable and `src_r_en_o=0`; on release the next beat follows with no bubble.
- Pointer skip: `rr_ptr=1` and only FIFOs 0 and 3 non-empty -> grant 3 first, then 0, after which `rr_ptr=1`.
- Reset mid-stream: assert `rst_n` low while `out_valid_o=1` and sources are busy -> `out_valid_o` drops immediately, `src_r_en_o=0`; after release the first grant goes to source 0.
